// File: rtl/ready_arbiter.sv
// Ready arbiter: latches per-player ready presses, waits until every active player is
// ready, then issues a rolled number and per-player go signals until the game clears it.
module ready_arbiter #(
    parameter int          NPLAYER       = 2,
    parameter int          NUM_W         = 4,
    parameter int          NUM_MAX       = 9,
    parameter int          TICK_DIV      = 5_000_000,
    parameter int          TIMEOUT_TICKS = 0,
    parameter logic [15:0] CLR_MASK      = 16'h0F40
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NPLAYER-1:0] READY,
    input  logic [NPLAYER-1:0] ACTIVE,
    input  logic [3:0]         STATE,
    output logic [NUM_W-1:0]   NUM,
    output logic [NPLAYER-1:0] OK,
    output logic [NPLAYER-1:0] LED,
    output logic               TIMEOUT,
    output logic [1:0]         DBG_FSM   // 0 = IDLE, 1 = COLLECT, 2 = HOLD
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } fsm_e;

    fsm_e               state_q, state_d;
    logic [NPLAYER-1:0] keep_q, keep_d;
    logic [NPLAYER-1:0] ok_q, ok_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   roll_q, roll_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               tout_q, tout_d;

    logic clr, tick, act_none, all_ready, tout_hit;

    always_comb begin
        clr       = CLR_MASK[STATE];
        tick      = (presc_q == PW'(TICK_DIV - 1));
        act_none  = (ACTIVE == '0);
        all_ready = !act_none && ((keep_q & ACTIVE) == ACTIVE);

        presc_d = tick ? '0 : presc_q + 1'b1;

        // The roll keeps spinning everywhere except HOLD, so the issued number stays fixed.
        roll_d = roll_q;
        if (tick && state_q != S_HOLD) begin
            roll_d = (roll_q == NUM_W'(NUM_MAX)) ? NUM_W'(1) : roll_q + 1'b1;
        end

        // All-ready beats an expiring timeout in the same cycle.
        tout_hit = (TIMEOUT_TICKS != 0) && (state_q == S_COLLECT) && tick &&
                   (tcnt_q == TW'(TIMEOUT_TICKS - 1)) && !all_ready && !act_none;

        keep_d = keep_q;
        if (state_q != S_HOLD) begin
            keep_d = keep_q | (READY & ACTIVE);
        end
        if (clr || tout_hit) begin
            keep_d = '0;
        end

        state_d = state_q;
        ok_d    = ok_q;
        num_d   = num_q;
        tcnt_d  = tcnt_q;
        tout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (all_ready) begin
                    state_d = S_HOLD;
                    ok_d    = ACTIVE;
                    num_d   = roll_q;
                end else if (keep_q != '0 && !act_none) begin
                    state_d = S_COLLECT;
                    tcnt_d  = '0;
                end
            end
            S_COLLECT: begin
                if (act_none) begin
                    state_d = S_IDLE;
                end else if (all_ready) begin
                    state_d = S_HOLD;
                    ok_d    = ACTIVE;
                    num_d   = roll_q;
                end else if (tout_hit) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                end else if (tick && TIMEOUT_TICKS != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (act_none) begin
                    state_d = S_IDLE;
                    ok_d    = '0;
                    num_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ok_d    = '0;
                num_d   = '0;
            end
        endcase

        if (clr) begin
            state_d = S_IDLE;
            ok_d    = '0;
            num_d   = '0;
            tout_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            keep_q  <= '0;
            ok_q    <= '0;
            num_q   <= '0;
            roll_q  <= NUM_W'(1);
            presc_q <= '0;
            tcnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            keep_q  <= keep_d;
            ok_q    <= ok_d;
            num_q   <= num_d;
            roll_q  <= roll_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            tout_q  <= tout_d;
        end
    end

    assign NUM     = num_q;
    assign OK      = ok_q;
    assign LED     = keep_q;
    assign TIMEOUT = tout_q;
    assign DBG_FSM = state_q;
endmodule

// File: tb/tb_ready_arbiter.sv
// Bench for ready_arbiter: directed scenarios with known answers plus a randomized run
// compared cycle by cycle against a tick-counting reference model.
module tb_ready_arbiter;
    localparam int NP  = 3;
    localparam int TD  = 4;
    localparam int NMX = 9;
    localparam int TTO = 5;

    logic       CLK;
    logic       rst;
    logic [2:0] ready, active;
    logic [3:0] st;
    logic [3:0] num;
    logic [2:0] ok, led;
    logic       tout;
    logic [1:0] dbg;

    logic [15:0] clr_mask = 16'h0F40;

    int tests_run = 0;
    int tests_failed = 0;

    ready_arbiter #(
        .NPLAYER(NP), .NUM_W(4), .NUM_MAX(NMX), .TICK_DIV(TD),
        .TIMEOUT_TICKS(TTO), .CLR_MASK(16'h0F40)
    ) dut (
        .CLK(CLK), .RST(rst), .READY(ready), .ACTIVE(active), .STATE(st),
        .NUM(num), .OK(ok), .LED(led), .TIMEOUT(tout), .DBG_FSM(dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: phases 0 idle, 1 collecting, 2 holding; roll derived from tick count.
    int         m_cyc, m_ticks, m_to, m_phase;
    logic [2:0] m_keep, m_ok;
    logic [3:0] m_num;
    logic       m_tout;

    task automatic model_step();
        bit         tick, clr, all, hit;
        int         old_phase;
        logic [2:0] nkeep;
        logic [3:0] roll;
        if (rst) begin
            m_cyc = 0; m_ticks = 0; m_to = 0; m_phase = 0;
            m_keep = '0; m_ok = '0; m_num = '0; m_tout = 1'b0;
            return;
        end
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        clr = clr_mask[st];
        all = (active != 0) && ((m_keep & active) == active);
        roll = 4'((m_ticks % NMX) + 1);
        old_phase = m_phase;
        hit = 0;
        m_tout = 1'b0;
        nkeep = (m_phase == 2) ? m_keep : (m_keep | (ready & active));
        if (m_phase == 0) begin
            if (all) begin
                m_phase = 2; m_ok = active; m_num = roll;
            end else if (m_keep != 0 && active != 0) begin
                m_phase = 1; m_to = 0;
            end
        end else if (m_phase == 1) begin
            if (active == 0) m_phase = 0;
            else if (all) begin
                m_phase = 2; m_ok = active; m_num = roll;
            end else if (tick) begin
                m_to++;
                if (m_to == TTO) begin
                    hit = 1; m_phase = 0; m_tout = 1'b1;
                end
            end
        end else if (active == 0) begin
            m_phase = 0; m_ok = '0; m_num = '0;
        end
        if (tick && old_phase != 2) m_ticks++;
        if (hit) nkeep = '0;
        if (clr) begin
            nkeep = '0; m_phase = 0; m_ok = '0; m_num = '0; m_tout = 1'b0;
        end
        m_keep = nkeep;
    endtask

    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = '0; st = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        active = 3'b111;
        ready = 3'b111;
        rst = 1'b1;
        cyc();
        rst = 1'b0; ready = '0;
        tests_run++;
        if ({num, ok, led, tout, dbg} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset: num=%0d ok=%b led=%b tout=%b fsm=%0d, required all zero", num, ok, led, tout, dbg);
        end
    endtask

    task automatic test_sequence_and_clear();
        do_reset();
        active = 3'b111;
        ready = 3'b001; cyc();
        ready = 3'b010; cyc();
        ready = 3'b100; cyc();
        ready = 3'b000;
        tests_run++;
        if (led !== 3'b111 || ok !== 3'b000) begin
            tests_failed++;
            $display("FAIL seq_led: led=%b ok=%b, required led=111 ok=000", led, ok);
        end
        cyc();
        tests_run++;
        if (ok !== 3'b111 || num !== 4'd1) begin
            tests_failed++;
            $display("FAIL seq_ok: ok=%b num=%0d, required ok=111 num=1", ok, num);
        end
        st = 4'b0111; cyc();
        tests_run++;
        if (ok !== 3'b111 || num !== 4'd1 || led !== 3'b111) begin
            tests_failed++;
            $display("FAIL non_clear_state: ok=%b num=%0d led=%b, required 111/1/111", ok, num, led);
        end
        st = 4'b1000; cyc();
        st = 4'b0000;
        tests_run++;
        if (ok !== 3'b000 || num !== 4'd0 || led !== 3'b000 || dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL clear_state: ok=%b num=%0d led=%b fsm=%0d, required 000/0/000/0", ok, num, led, dbg);
        end
    endtask

    task automatic test_roll_freeze();
        do_reset();
        active = 3'b111;
        for (int i = 0; i < 40; i++) cyc();
        ready = 3'b111; cyc();
        ready = 3'b000; cyc();
        tests_run++;
        if (ok !== 3'b111 || num !== 4'd2) begin
            tests_failed++;
            $display("FAIL roll_10_ticks: ok=%b num=%0d, required ok=111 num=2", ok, num);
        end
        for (int i = 0; i < 20; i++) cyc();
        tests_run++;
        if (ok !== 3'b111 || num !== 4'd2) begin
            tests_failed++;
            $display("FAIL hold_stable: ok=%b num=%0d, required ok=111 num=2", ok, num);
        end
        st = 4'b1000; cyc();
        st = 4'b0000;
        // Ticks inside HOLD are skipped; only the tick on the next press edge advances 2 -> 3.
        ready = 3'b111; cyc();
        ready = 3'b000; cyc();
        tests_run++;
        if (num !== 4'd3) begin
            tests_failed++;
            $display("FAIL roll_frozen: num=%0d, required 3", num);
        end
        st = 4'b1000; cyc();
        st = 4'b0000;
    endtask

    task automatic test_timeout();
        int pulses, pulse_at;
        bit ok_seen;
        do_reset();
        active = 3'b111;
        pulses = 0; pulse_at = -1; ok_seen = 0;
        ready = 3'b001; cyc();
        ready = 3'b000;
        for (int e = 2; e <= 40; e++) begin
            cyc();
            if (tout === 1'b1) begin
                pulses++;
                pulse_at = e;
            end
            if (ok !== 3'b000) ok_seen = 1;
        end
        tests_run++;
        if (pulses != 1 || pulse_at != 20) begin
            tests_failed++;
            $display("FAIL timeout_pulse: pulses=%0d at edge %0d, required 1 at edge 20", pulses, pulse_at);
        end
        tests_run++;
        if (ok_seen || led !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_clear: ok_seen=%0d led=%b, required 0 and 000", ok_seen, led);
        end
    endtask

    task automatic test_active_mask();
        do_reset();
        active = 3'b000;
        ready = 3'b111; cyc(); cyc();
        ready = 3'b000;
        tests_run++;
        if (led !== 3'b000 || ok !== 3'b000 || dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL no_active: led=%b ok=%b fsm=%0d, required 000/000/0", led, ok, dbg);
        end
        active = 3'b101;
        ready = 3'b101; cyc();
        ready = 3'b000; cyc();
        tests_run++;
        if (ok !== 3'b101 || led !== 3'b101) begin
            tests_failed++;
            $display("FAIL masked_ok: ok=%b led=%b, required 101/101", ok, led);
        end
        active = 3'b111;
        ready = 3'b010; cyc();
        ready = 3'b000; cyc();
        tests_run++;
        if (ok !== 3'b101 || led !== 3'b101) begin
            tests_failed++;
            $display("FAIL hold_ignores_ready: ok=%b led=%b, required 101/101", ok, led);
        end
        ready = 3'b010; st = 4'b1000; cyc();
        ready = 3'b000; st = 4'b0000; cyc();
        tests_run++;
        if (led !== 3'b000 || ok !== 3'b000) begin
            tests_failed++;
            $display("FAIL clear_beats_ready: led=%b ok=%b, required 000/000", led, ok);
        end
    endtask

    task automatic test_random();
        do_reset();
        active = 3'b111;
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 3; b++) ready[b] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) begin
                active = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            end
            st = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            cyc();
            tests_run++;
            if (num !== m_num || ok !== m_ok || led !== m_keep || tout !== m_tout) begin
                tests_failed++;
                $display("FAIL random c=%0d: num=%0d ok=%b led=%b tout=%b, required num=%0d ok=%b led=%b tout=%b",
                         c, num, ok, led, tout, m_num, m_ok, m_keep, m_tout);
            end
        end
        rst = 1'b0; ready = '0; st = '0;
    endtask

    initial begin
        rst = 1'b1; ready = '0; active = 3'b111; st = '0;
        test_reset();
        test_sequence_and_clear();
        test_roll_freeze();
        test_timeout();
        test_active_mask();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ready_arbiter.md
READY_ARBITER -- requirements
Module: ready_arbiter

Interface
REQ-001 SHALL have parameter NPLAYER, default 2, number of player channels (2..8).
REQ-002 SHALL have parameter NUM_W, default 4, width of issued number.
REQ-003 SHALL have parameter NUM_MAX, default 9, largest issued number (1..2^NUM_W-1).
REQ-004 SHALL have parameter TICK_DIV, default 5_000_000, CLK cycles per roll tick (>=2).
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 0, ticks allowed in COLLECT; 0 disables timeout.
REQ-006 SHALL have parameter CLR_MASK, default 16'h0F40, bit s set means STATE==s clears the block (DRAW, GOOD, OUCH, WIN, LOSE).
REQ-007 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-008 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port READY  input  NPLAYER  per-player ready press, bit i = player i+1.
REQ-010 SHALL have port ACTIVE  input  NPLAYER  participating players; inactive bits ignored.
REQ-011 SHALL have port STATE  input  4  game controller state.
REQ-012 SHALL have port NUM  output  NUM_W  issued number, broadcast to all players.
REQ-013 SHALL have port OK  output  NPLAYER  per-player go to control sections.
REQ-014 SHALL have port LED  output  NPLAYER  per-player latched-ready indicator.
REQ-015 SHALL have port TIMEOUT  output  1  one-cycle pulse on collect timeout.

Function
REQ-016 SHALL keep latch keep[i], set the cycle after READY[i]=1 with ACTIVE[i]=1, held until clear; LED = keep, registered.
REQ-017 SHALL treat clear = RST or CLR_MASK[STATE]; clear has priority over READY in the same cycle.
REQ-018 SHALL implement FSM IDLE, COLLECT, HOLD; reset state IDLE.
REQ-019 IDLE->COLLECT when any keep bit set; COLLECT->HOLD when (keep & ACTIVE)==ACTIVE and ACTIVE!=0; HOLD->IDLE on clear; any state->IDLE on clear.
REQ-020 ACTIVE==0 SHALL hold FSM in IDLE and OK at 0.
REQ-021 SHALL run prescaler 0..TICK_DIV-1; tick when count==TICK_DIV-1, count wraps to 0; free-running except reset.
REQ-022 SHALL run roll counter 1..NUM_MAX, advanced by tick when state!=HOLD, NUM_MAX wraps to 1; frozen in HOLD.
REQ-023 On COLLECT->HOLD edge, NUM SHALL load roll value and OK SHALL load ACTIVE; both held constant throughout HOLD.
REQ-024 OK/NUM latency: OK asserts exactly 1 cycle after last required keep bit reads 1 (2 cycles after last READY press).
REQ-025 Outside HOLD, NUM SHALL be 0 and OK SHALL be 0.
REQ-026 READY presses in HOLD SHALL be ignored (no state/output change).
REQ-027 With TIMEOUT_TICKS>0, ticks SHALL be counted in COLLECT (counter zeroed on entry); on reaching TIMEOUT_TICKS: TIMEOUT=1 for one cycle, all keep cleared, FSM->IDLE.
REQ-028 If all-ready and timeout expiry coincide, all-ready SHALL win (HOLD, no TIMEOUT).
REQ-029 ACTIVE change during COLLECT SHALL be reevaluated every cycle; keep bits of deactivated players are retained but not required.

Reset
REQ-030 On RST: NUM=0, OK=0, LED=0, TIMEOUT=0, keep=0, FSM IDLE, prescaler 0, roll=1, timeout counter 0.
REQ-031 RST mid-HOLD or mid-COLLECT SHALL take effect next edge, same values as REQ-030.

Verification (NPLAYER=3, TICK_DIV=4, NUM_MAX=9, TIMEOUT_TICKS=5, ACTIVE=3'b111)
REQ-032 After reset, no ticks elapsed, READY pulses 001,010,100 on cycles 1,2,3 -> LED=111 at cycle 4, OK=111 and NUM=1 at cycle 5.
REQ-033 Hold all READY low 40 cycles (10 ticks) then all press together -> NUM=(10 mod 9)+1=2, OK=111; roll frozen while HOLD.
REQ-034 In HOLD, STATE=4'b1000 one cycle -> next edge OK=000, NUM=0, LED=000, FSM IDLE; STATE=4'b0111 -> no change.
REQ-035 Press only player 1, wait 5 ticks -> TIMEOUT single-cycle pulse, LED=000, OK never asserted.
REQ-036 ACTIVE=3'b101, players 1 and 3 press -> OK=101; READY[1] asserted with clear STATE in same cycle -> LED[1] stays 0.
